// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the counter-increment scheduler.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int MIN_GAP_DEF = 3;
    localparam int CNT_W_DEF   = 2;
    localparam int GAP_W       = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first asserted req at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               vld,
    output logic [IDX_W-1:0]   idx
);

    int j;

    // Scan offsets high to low so the nearest hit overwrites the rest.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                vld = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/count_en_sched.sv
// Round-robin scheduler for counter increments with an enforced idle gap.
module count_en_sched
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_ref,
    input  logic               rst,
    input  logic               sched_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               en_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               wrap_o,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W-1:0]   gnt_id_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               en_d, wrap_d, busy_d;
    logic               arb;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id;
        cnt_d    = cnt_o;
        en_d     = 1'b0;
        wrap_d   = 1'b0;
        arb      = 1'b0;
        unique case (state_q)
            IDLE: arb = 1'b1;
            GRANT: begin
                state_d = GAP;
                gap_d   = GAP_W'(MIN_GAP);
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GAP_W'(1)) arb = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Grant side effects are computed here so every output is a flop.
        if (arb) begin
            if (sched_en && pick_vld) begin
                state_d  = GRANT;
                gnt_d    = NUM_REQ'(1) << pick_idx;
                gnt_id_d = pick_idx;
                en_d     = 1'b1;
                cnt_d    = cnt_o + 1'b1;
                wrap_d   = &cnt_o;
                ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1))
                         ? '0 : pick_idx + 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            ptr_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            en_o    <= 1'b0;
            cnt_o   <= '0;
            wrap_o  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            en_o    <= en_d;
            cnt_o   <= cnt_d;
            wrap_o  <= wrap_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_count_en_sched.sv
// Directed self-checking bench for count_en_sched (NUM_REQ=4, MIN_GAP=3).
module tb_count_en_sched;

    logic       clk_ref  = 1'b0;
    logic       rst      = 1'b0;
    logic       sched_en = 1'b0;
    logic [3:0] req      = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       en_o;
    logic [1:0] cnt_o;
    logic       wrap_o;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_ref = ~clk_ref;

    count_en_sched #(
        .NUM_REQ (4),
        .MIN_GAP (3),
        .CNT_W   (2)
    ) dut (
        .clk_ref  (clk_ref),
        .rst      (rst),
        .sched_en (sched_en),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .en_o     (en_o),
        .cnt_o    (cnt_o),
        .wrap_o   (wrap_o),
        .busy     (busy)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_ref);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        sched_en = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},  32'(gnt),    32'h0);
        check({tag, "_en"},   32'(en_o),   32'h0);
        check({tag, "_busy"}, 32'(busy),   32'h0);
        check({tag, "_id"},   32'(gnt_id), 32'h0);
        check({tag, "_cnt"},  32'(cnt_o),  32'h0);
        check({tag, "_wrap"}, 32'(wrap_o), 32'h0);
    endtask

    initial begin
        logic [31:0] id_exp;
        logic        en_exp;

        #1;
        check_zero("rst");

        // single request, cnt 0->1, busy for 4 cycles
        do_reset();
        sched_en = 1'b1;
        step();
        req = 4'b0100;
        step();
        check("one_gnt",  32'(gnt),    32'h4);
        check("one_en",   32'(en_o),   32'h1);
        check("one_id",   32'(gnt_id), 32'h2);
        check("one_cnt",  32'(cnt_o),  32'h1);
        check("one_busy", 32'(busy),   32'h1);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("one_gap_busy", 32'(busy), 32'h1);
            check("one_gap_en",   32'(en_o), 32'h0);
            check("one_gap_gnt",  32'(gnt),  32'h0);
        end
        step();
        check("one_idle_busy", 32'(busy),  32'h0);
        check("one_hold_id",   32'(gnt_id), 32'h2);

        // all requesting: order 0,1,2,3,0 every 4 cycles, wrap on 4th
        do_reset();
        sched_en = 1'b1;
        req      = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            step();
            en_exp = ((k % 4) == 1);
            id_exp = ((k - 1) / 4) % 4;
            check("rr_en",   32'(en_o),   32'(en_exp));
            check("rr_wrap", 32'(wrap_o), 32'(k == 13));
            if (en_exp) begin
                check("rr_gnt", 32'(gnt),    32'h1 << id_exp);
                check("rr_id",  32'(gnt_id), id_exp);
                check("rr_cnt", 32'(cnt_o), 32'((((k - 1) / 4) + 1) % 4));
            end else begin
                check("rr_gnt_idle", 32'(gnt), 32'h0);
            end
        end

        // sched_en low blocks; falling during GAP does not abort it
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            step();
            check("blk_gnt", 32'(gnt), 32'h0);
        end
        sched_en = 1'b1;
        step();
        check("blk_rel_gnt", 32'(gnt),    32'h1);
        check("blk_rel_id",  32'(gnt_id), 32'h0);
        sched_en = 1'b0;
        req      = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            check("blk_gap_busy", 32'(busy), 32'h1);
            check("blk_gap_en",   32'(en_o), 32'h0);
        end
        step();
        check("blk_end_busy", 32'(busy), 32'h0);
        step();
        check("blk_end_gnt", 32'(gnt), 32'h0);

        // withdrawal during GAP is never granted
        do_reset();
        sched_en = 1'b1;
        req      = 4'b0001;
        step();
        check("wd_gnt0", 32'(gnt), 32'h1);
        req = '0;
        step();
        req = 4'b0010;
        step();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("wd_gnt", 32'(gnt),  32'h0);
            check("wd_en",  32'(en_o), 32'h0);
        end

        // reset mid-GAP clears outputs at once; lowest index wins after
        req = 4'b1000;
        step();
        check("rg_gnt", 32'(gnt),   32'h8);
        check("rg_cnt", 32'(cnt_o), 32'h2);
        req = 4'b0110;
        step();
        check("rg_gap_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check_zero("rg_async");
        step();
        check_zero("rg_held");
        step();
        rst = 1'b1;
        step();
        check("rg_post_gnt", 32'(gnt),    32'h2);
        check("rg_post_id",  32'(gnt_id), 32'h1);
        check("rg_post_en",  32'(en_o),   32'h1);
        check("rg_post_cnt", 32'(cnt_o),  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_en_sched.md
COUNT_EN_SCHED -- requirements
Module: count_en_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the counter increment (2..8).
REQ-002 Parameter MIN_GAP, default 3, idle cycles forced after every increment so the Gray-coded CDC transfer stays lossless (1..15).
REQ-003 Parameter CNT_W, default 2, width of the shadow count (matches the downstream counter).
REQ-004 clk_ref  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 sched_en  in  1  scheduler enable; low blocks new grants.
REQ-007 req  in  NUM_REQ  per-requester increment request, level, held until granted.
REQ-008 gnt  out  NUM_REQ  one-hot single-cycle grant pulse, registered.
REQ-009 gnt_id  out  clog2(NUM_REQ)  index of the current or last winner, registered.
REQ-010 en_o  out  1  increment enable to the counter, registered, asserted exactly when gnt is non-zero.
REQ-011 cnt_o  out  CNT_W  shadow of the counter value, updated on each en_o.
REQ-012 wrap_o  out  1  single-cycle pulse, asserted on the en_o cycle where cnt_o goes from all-ones to zero.
REQ-013 busy  out  1  high in GRANT and GAP states.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-015 IDLE: if sched_en=1 and req≠0, the next state SHALL be GRANT with the round-robin winner latched; otherwise it SHALL stay in IDLE.
REQ-016 GRANT (exactly 1 cycle): gnt[winner]=1, en_o=1, gnt_id=winner, cnt_o+=1 modulo 2^CNT_W, and the pointer set to winner+1 mod NUM_REQ; the next state SHALL be GAP with gap_cnt=MIN_GAP.
REQ-017 GAP: gap_cnt SHALL decrement each cycle; in the cycle gap_cnt=1, arbitration SHALL be evaluated as in IDLE, with the next state GRANT if eligible, otherwise IDLE.
REQ-018 Latency: req rising in IDLE at cycle t SHALL produce gnt/en_o at t+1.
REQ-019 Back-to-back en_o pulses SHALL be spaced exactly MIN_GAP+1 cycles under continuous requests, and never less.
REQ-020 Round robin: search SHALL start at the pointer and ascend with wrap-around; the first asserted req wins.
REQ-021 Handshake: a requester SHALL deassert req the cycle after gnt; req still high after that cycle SHALL be treated as a new request.
REQ-022 Withdrawal: req dropping before grant SHALL be legal and SHALL NOT be granted.
REQ-023 sched_en falling during GRANT or GAP SHALL NOT abort the grant or GAP; it SHALL only block the next arbitration.
REQ-024 cnt_o SHALL wrap from 2^CNT_W-1 to 0, with wrap_o=1 in that same cycle.
REQ-025 gnt and en_o SHALL never be asserted outside GRANT, and gnt SHALL never have more than one bit set.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, gnt=0, en_o=0, wrap_o=0, busy=0, gnt_id=0, cnt_o=0, gap_cnt=0, and pointer=0.
REQ-027 Reset asserted mid-GRANT or mid-GAP SHALL drop the pending grant and SHALL NOT leave any partial en_o pulse after release.
REQ-028 The first arbitration after reset release SHALL favour requester 0.

Structure
REQ-029 Package count_sched_pkg SHALL hold the state enum (IDLE/GRANT/GAP) and the MIN_GAP/NUM_REQ defaults.
REQ-030 One sub-module, rr_pick, SHALL perform the combinational round-robin search (req, pointer -> valid, index).
REQ-031 All outputs SHALL be registered; no combinational path SHALL run from req to en_o.

Verification
REQ-032 Single request: req=4'b0100 at cycle 10 in IDLE -> gnt=4'b0100, en_o=1, gnt_id=2 and cnt_o 0->1 at cycle 11; busy high for cycles 11-14.
REQ-033 All requesting: req=4'b1111 held (re-asserted after each grant) -> grant order 0,1,2,3,0 with en_o every 4 cycles for MIN_GAP=3.
REQ-034 Wrap: 4 grants from reset -> cnt_o sequence 1,2,3,0, with wrap_o=1 only on the fourth en_o.
REQ-035 sched_en=0 while req=4'b0011 -> no gnt for 20 cycles; sched_en=1 -> gnt=4'b0001 next cycle.
REQ-036 Withdrawal and reset: req[1] pulsed during GAP and removed before its end -> no gnt[1]; rst=0 during GAP -> all outputs 0 at once, and the first grant after release goes to the lowest requesting index.
